// File: rtl/serial_frame_loader_pkg.sv
// Shared types and constants for the serial frame loader: FSM states,
// header sync/opcode encodings and the checksum width.
package serial_frame_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    localparam logic [1:0] OP_RSVD  = 2'b00;
    localparam logic [1:0] OP_KEY   = 2'b01;
    localparam logic [1:0] OP_MSG   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int CSUM_W = 8;

    // Header is acceptable when the sync nibble matches and the opcode is not reserved.
    function automatic logic header_ok(input logic [CSUM_W-1:0] hdr);
        return (hdr[7:4] == SYNC_NIBBLE) && (hdr[1:0] != OP_RSVD);
    endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-bit gap timer: counts enabled idle cycles while a frame is open and
// flags the edge on which the gap reaches TIMEOUT.
module frame_gap_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic start,
    input  logic kick,
    output logic oTimeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] gap_cnt_reg;

    // A sampled bit on the same edge always wins over the timeout.
    assign oTimeout = start && ena && !kick && (gap_cnt_reg == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_reg <= '0;
        end else if (!start || kick || oTimeout) begin
            gap_cnt_reg <= '0;
        end else if (ena) begin
            gap_cnt_reg <= gap_cnt_reg + 16'd1;
        end
    end

endmodule

// File: rtl/serial_frame_loader.sv
// Framed serial loader for key/message words. Define FRAME_CHECKSUM_EN to
// require and verify a trailing XOR checksum byte after the payload.
module serial_frame_loader
    import serial_frame_loader_pkg::*;
#(
    parameter int KEY_SIZE = 8,
    parameter int MSG_SIZE = 64,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                iSer_data,
    input  logic                iSer_valid,
    output logic [KEY_SIZE-1:0] oKey,
    output logic [MSG_SIZE-1:0] oMessage,
    output logic                oKey_valid,
    output logic                oMsg_valid,
    output logic                oFrame_err,
    output logic [3:0]          oErr_count,
    output logic                oBusy
);

    localparam int CNT_W = $clog2(MSG_SIZE) + 1;
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_SIZE - 1);
    localparam logic [CNT_W-1:0] MSG_LAST  = CNT_W'(MSG_SIZE - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(CSUM_W - 1);

    state_t              state_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [CSUM_W-1:0]   shift8_reg;
    logic [1:0]          opcode_reg;
    logic [MSG_SIZE-1:0] stage_reg;
    logic [KEY_SIZE-1:0] key_reg;
    logic [MSG_SIZE-1:0] msg_reg;
    logic                key_valid_reg;
    logic                msg_valid_reg;
    logic                frame_err_reg;
    logic [3:0]          err_count_reg;
`ifdef FRAME_CHECKSUM_EN
    logic [CSUM_W-1:0]   csum_reg;
    logic [CSUM_W-1:0]   csum_next;
`endif

    logic                sample;
    logic                gap_timeout;
    logic [CSUM_W-1:0]   shift8_next;
    logic [MSG_SIZE-1:0] stage_next;
    logic [MSG_SIZE-1:0] stage_commit;
    logic                payload_last;
    logic                commit;
    logic                abort;
    logic [1:0]          commit_op;

    assign sample = ena && iSer_valid;

    frame_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (state_reg != IDLE),
        .kick     (sample),
        .oTimeout (gap_timeout)
    );

    assign shift8_next  = {shift8_reg[CSUM_W-2:0], iSer_data};
    assign stage_next   = {stage_reg[MSG_SIZE-2:0], iSer_data};
    assign payload_last = (opcode_reg == OP_KEY) ? (bit_cnt_reg == KEY_LAST)
                                                 : (bit_cnt_reg == MSG_LAST);
`ifdef FRAME_CHECKSUM_EN
    // Payload bit n lands at position 7-(n mod 8) of its byte, so each bit
    // folds straight into the running XOR without assembling bytes.
    assign csum_next    = iSer_data ? (csum_reg ^ (8'h80 >> bit_cnt_reg[2:0])) : csum_reg;
    assign stage_commit = stage_reg;
`else
    assign stage_commit = stage_next;
`endif

    always_comb begin
        commit    = 1'b0;
        abort     = 1'b0;
        commit_op = opcode_reg;
        if (gap_timeout) begin
            abort = 1'b1;
        end else if (sample) begin
            case (state_reg)
                HEADER: begin
                    if (bit_cnt_reg == BYTE_LAST) begin
                        if (!header_ok(shift8_next)) begin
                            abort = 1'b1;
                        end
`ifndef FRAME_CHECKSUM_EN
                        else if (shift8_next[1:0] == OP_CLEAR) begin
                            commit    = 1'b1;
                            commit_op = OP_CLEAR;
                        end
`endif
                    end
                end
                PAYLOAD: begin
`ifndef FRAME_CHECKSUM_EN
                    commit = payload_last;
`endif
                end
                CHECK: begin
`ifdef FRAME_CHECKSUM_EN
                    if (bit_cnt_reg == BYTE_LAST) begin
                        commit = (shift8_next == csum_reg);
                        abort  = (shift8_next != csum_reg);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift8_reg    <= '0;
            opcode_reg    <= OP_RSVD;
            stage_reg     <= '0;
            key_reg       <= '0;
            msg_reg       <= '0;
            key_valid_reg <= 1'b0;
            msg_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            err_count_reg <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            key_valid_reg <= 1'b0;
            msg_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;

            if (commit || abort) begin
                state_reg   <= IDLE;
                bit_cnt_reg <= '0;
            end else if (sample) begin
                case (state_reg)
                    IDLE: begin
                        shift8_reg  <= shift8_next;
                        bit_cnt_reg <= CNT_W'(1);
                        state_reg   <= HEADER;
                    end
                    HEADER: begin
                        shift8_reg <= shift8_next;
                        if (bit_cnt_reg == BYTE_LAST) begin
                            bit_cnt_reg <= '0;
                            opcode_reg  <= shift8_next[1:0];
`ifdef FRAME_CHECKSUM_EN
                            csum_reg    <= shift8_next;
                            state_reg   <= (shift8_next[1:0] == OP_CLEAR) ? CHECK : PAYLOAD;
`else
                            state_reg   <= PAYLOAD;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                    PAYLOAD: begin
                        stage_reg   <= stage_next;
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
`ifdef FRAME_CHECKSUM_EN
                        csum_reg    <= csum_next;
                        if (payload_last) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= CHECK;
                        end
`endif
                    end
                    CHECK: begin
                        shift8_reg  <= shift8_next;
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                    default: state_reg <= IDLE;
                endcase
            end

            if (commit) begin
                case (commit_op)
                    OP_KEY: begin
                        key_reg       <= stage_commit[KEY_SIZE-1:0];
                        key_valid_reg <= 1'b1;
                    end
                    OP_MSG: begin
                        msg_reg       <= stage_commit;
                        msg_valid_reg <= 1'b1;
                    end
                    OP_CLEAR: begin
                        key_reg       <= '0;
                        msg_reg       <= '0;
                        key_valid_reg <= 1'b1;
                        msg_valid_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (abort) begin
                frame_err_reg <= 1'b1;
                if (err_count_reg != 4'hF) begin
                    err_count_reg <= err_count_reg + 4'd1;
                end
            end
        end
    end

    assign oKey       = key_reg;
    assign oMessage   = msg_reg;
    assign oKey_valid = key_valid_reg;
    assign oMsg_valid = msg_valid_reg;
    assign oFrame_err = frame_err_reg;
    assign oErr_count = err_count_reg;
    assign oBusy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_frame_loader.sv
// Scoreboard bench for serial_frame_loader; follows FRAME_CHECKSUM_EN to
// decide whether frames carry a checksum byte.
module tb_serial_frame_loader;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        iSer_data = 1'b0;
    logic        iSer_valid = 1'b0;
    logic [7:0]  oKey;
    logic [63:0] oMessage;
    logic        oKey_valid;
    logic        oMsg_valid;
    logic        oFrame_err;
    logic [3:0]  oErr_count;
    logic        oBusy;

    serial_frame_loader #(
        .KEY_SIZE (8),
        .MSG_SIZE (64),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .iSer_data  (iSer_data),
        .iSer_valid (iSer_valid),
        .oKey       (oKey),
        .oMessage   (oMessage),
        .oKey_valid (oKey_valid),
        .oMsg_valid (oMsg_valid),
        .oFrame_err (oFrame_err),
        .oErr_count (oErr_count),
        .oBusy      (oBusy)
    );

    always #5 clk = ~clk;

    int pos_cnt = 0;
    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    typedef struct {
        logic        kv;
        logic        mv;
        logic        er;
        logic [7:0]  key;
        logic [63:0] msg;
        logic [3:0]  ec;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int last_bit_cyc = 0;
    logic [7:0]  exp_key = '0;
    logic [63:0] exp_msg = '0;
    logic [3:0]  exp_err = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic kv, input logic mv, input logic er, input int cyc);
        exp_t e;
        e.kv = kv; e.mv = mv; e.er = er;
        e.key = exp_key; e.msg = exp_msg; e.ec = exp_err; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic expect_key(input logic [7:0] k);
        exp_key = k;
        push(1'b1, 1'b0, 1'b0, last_bit_cyc + 1);
    endtask

    task automatic expect_msg(input logic [63:0] m);
        exp_msg = m;
        push(1'b0, 1'b1, 1'b0, last_bit_cyc + 1);
    endtask

    task automatic expect_clear();
        exp_key = '0;
        exp_msg = '0;
        push(1'b1, 1'b1, 1'b0, last_bit_cyc + 1);
    endtask

    task automatic expect_err(input int delay);
        if (exp_err != 4'hF) exp_err = exp_err + 4'd1;
        push(1'b0, 1'b0, 1'b1, last_bit_cyc + delay);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        iSer_valid   = 1'b1;
        iSer_data    = b;
        last_bit_cyc = pos_cnt;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits({56'd0, v}, 8);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iSer_valid = 1'b0;
            iSer_data  = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [63:0] payload,
                              input int nbits, input logic [7:0] csum);
        send_byte(hdr);
        if (nbits > 0) send_bits(payload, nbits);
`ifdef FRAME_CHECKSUM_EN
        send_byte(csum);
`else
        if (csum === 8'hxx) $display("note: checksum byte unused");
`endif
    endtask

    // Monitor: every cycle carrying a pulse must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (oKey_valid || oMsg_valid || oFrame_err) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_pulse: got kv=%b mv=%b err=%b expected no pulse (t=%0t)",
                             oKey_valid, oMsg_valid, oFrame_err, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_valid", 64'(oKey_valid), 64'(e.kv));
                    chk("msg_valid", 64'(oMsg_valid), 64'(e.mv));
                    chk("frame_err", 64'(oFrame_err), 64'(e.er));
                    chk("key", 64'(oKey), 64'(e.key));
                    chk("message", oMessage, e.msg);
                    chk("err_count", 64'(oErr_count), 64'(e.ec));
                    chk("pulse_cycle", 64'(pos_cnt), 64'(e.cyc));
                    $display("txn kv=%b mv=%b err=%b key=%h msg=%h errs=%0d cyc=%0d",
                             oKey_valid, oMsg_valid, oFrame_err, oKey, oMessage, oErr_count, pos_cnt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_key", 64'(oKey), 64'd0);
        chk("rst_msg", oMessage, 64'd0);
        chk("rst_errcnt", 64'(oErr_count), 64'd0);
        chk("rst_busy", 64'(oBusy), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Key frame; busy must be up while the header is arriving
        send_byte(8'hA1);
        chk("busy_in_frame", 64'(oBusy), 64'd1);
        send_bits(64'hAC, 8);
`ifdef FRAME_CHECKSUM_EN
        send_byte(8'h0D);
`endif
        expect_key(8'hAC);
        idle(3);
        chk("busy_after_commit", 64'(oBusy), 64'd0);

        // Message frame
        send_frame(8'hA2, 64'h0123456789ABCDEF, 64, 8'hA2);
        expect_msg(64'h0123456789ABCDEF);
        idle(3);

`ifdef FRAME_CHECKSUM_EN
        // Bad checksum
        send_frame(8'hA1, 64'hAC, 8, 8'h0C);
        expect_err(1);
        idle(3);
`endif

        // Bad sync, then reserved opcode
        send_byte(8'hB1);
        expect_err(1);
        idle(1);
        chk("idle_after_bad_sync", 64'(oBusy), 64'd0);
        send_byte(8'hA0);
        expect_err(1);
        idle(1);
        chk("idle_after_rsvd_op", 64'(oBusy), 64'd0);
        idle(2);

        // Gap timeout after 20 message bits, then a clean key frame
        send_byte(8'hA2);
        send_bits(64'h01234, 20);
        expect_err(1 + TB_TIMEOUT);
        idle(8);
        send_frame(8'hA1, 64'h5A, 8, 8'hFB);
        expect_key(8'h5A);
        idle(3);

        // ena low longer than the timeout mid-frame: nothing sampled, no timeout
        send_byte(8'hA1);
        @(negedge clk);
        ena = 1'b0;
        iSer_valid = 1'b1;
        iSer_data = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_hold_ena_low", 64'(oBusy), 64'd1);
        ena = 1'b1;
        iSer_valid = 1'b0;
        send_bits(64'h3C, 8);
`ifdef FRAME_CHECKSUM_EN
        send_byte(8'h9D);
`endif
        expect_key(8'h3C);
        idle(3);

        // Back-to-back CLEAR frames
        send_frame(8'hA3, 64'd0, 0, 8'hA3);
        expect_clear();
        send_frame(8'hA3, 64'd0, 0, 8'hA3);
        expect_clear();
        idle(3);

        // Reload, then async reset mid-payload
        send_frame(8'hA1, 64'h77, 8, 8'hD6);
        expect_key(8'h77);
        idle(2);
        send_byte(8'hA2);
        send_bits(64'h2AB, 10);
        #2;
        rst_n = 1'b0;
        iSer_valid = 1'b0;
        #1;
        chk("async_rst_busy", 64'(oBusy), 64'd0);
        chk("async_rst_key", 64'(oKey), 64'd0);
        chk("async_rst_errcnt", 64'(oErr_count), 64'd0);
        exp_key = '0;
        exp_msg = '0;
        exp_err = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        send_frame(8'hA1, 64'hC3, 8, 8'h62);
        expect_key(8'hC3);

        idle(10);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_loader.md
# serial_frame_loader

Upstream loader for the XOR encryption datapath. It replaces the separate raw key and message strobes with a single framed serial protocol on one data line. It checks sync, opcode, checksum and inter-bit gap, then presents a parallel key or message with one-cycle valid pulses for the key/message capture stage and the XOR stage.

## Interface
- `KEY_SIZE`, default 8: key width in bits; must be a multiple of 8.
- `MSG_SIZE`, default 64: message width in bits; must be a multiple of 8.
- `TIMEOUT`, default 255: maximum idle cycles allowed between valid bits inside a frame; range 1–65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: global enable; when low, all state, counters and outputs hold.
- `iSer_data` in 1: serial data, MSB first.
- `iSer_valid` in 1: `iSer_data` is sampled on an edge where `ena && iSer_valid`.
- `oKey` out KEY_SIZE: last committed key.
- `oMessage` out MSG_SIZE: last committed message.
- `oKey_valid` out 1: one-cycle pulse when `oKey` is updated.
- `oMsg_valid` out 1: one-cycle pulse when `oMessage` is updated.
- `oFrame_err` out 1: one-cycle pulse on any frame abort.
- `oErr_count` out 4: number of errors, saturating at 15.
- `oBusy` out 1: high whenever the state is not IDLE.

## Operation
- **Frame layout**
  - Header byte: `[7:4]` = sync 4'hA; `[3:2]` ignored; `[1:0]` = opcode.
  - Then the payload.
  - Then the checksum byte (configurable, see Configuration).
- **Opcodes**
  - 2'b01 KEY: payload is KEY_SIZE bits.
  - 2'b10 MSG: payload is MSG_SIZE bits.
  - 2'b11 CLEAR: no payload.
  - 2'b00: reserved, treated as an error.
- **Checksum**: XOR of the header byte and every payload byte. Payload bytes are taken MSB-first, in the order they were received.
- **States**
  - IDLE: the first sampled bit enters the header shift register; go to HEADER with bit count 1.
  - HEADER: after 8 bits, check sync and opcode.
    - Bad sync or reserved opcode: error, go to IDLE.
    - Otherwise go to PAYLOAD. For CLEAR, go straight to CHECK, or commit immediately when the checksum is compiled out.
  - PAYLOAD: shift bits into a MSG_SIZE-wide staging register and accumulate the running byte XOR. When the bit count equals the payload length, go to CHECK, or commit when the checksum is compiled out.
  - CHECK: after 8 bits, compare with the accumulated checksum.
    - Match: commit.
    - Mismatch: error, go to IDLE.
- **Commit**: happens on the same edge that samples the frame's last bit.
  - KEY: load `oKey` from the low KEY_SIZE staging bits and pulse `oKey_valid`.
  - MSG: load `oMessage` and pulse `oMsg_valid`.
  - CLEAR: zero both outputs and pulse both valids.
  - The FSM returns to IDLE on that same edge, so a new frame may start on the very next sampled bit.
- **Error**
  - Pulse `oFrame_err` and increment `oErr_count` (saturating).
  - Staging is discarded; `oKey` and `oMessage` are unchanged.
- **Gap timer**
  - Counts `ena`-qualified cycles with `iSer_valid` low while not in IDLE.
  - Reaching TIMEOUT aborts the frame as an error.
  - Cleared on every sampled bit.
  - Never runs in IDLE.
- **Bit counter** width is `$clog2(MSG_SIZE)+1`. It resets to 0 on every state change.

## Timing
- Reset values:
  - `oKey`, `oMessage`, `oErr_count`: 0.
  - All pulses and `oBusy`: 0.
  - State: IDLE; all counters 0.
- Reset asserted mid-frame: immediate return to IDLE, with no pulse and no error.
- Latency: valid and error pulses are high in the cycle after the edge that sampled the last bit (or the timeout edge).
- `oBusy` is high from the cycle after the first header bit until the cycle after commit or abort.
- `ena` low: pulses deassert after one cycle and do not re-fire. The timer does not advance.
- A timeout edge that coincides with a sampled bit: the bit wins and the timer clears.

## Configuration
- `FRAME_CHECKSUM_EN` defined: a checksum byte is required and checked as described above.
- `FRAME_CHECKSUM_EN` undefined:
  - The frame ends after the payload; the CHECK state and XOR accumulator are absent.
  - CLEAR commits at the end of the header.
  - The only error sources are bad sync, reserved opcode and timeout.

## Structure
- Package `serial_frame_loader_pkg` holds:
  - the state enum (IDLE, HEADER, PAYLOAD, CHECK);
  - `SYNC_NIBBLE` = 4'hA;
  - the opcode constants;
  - the checksum width constant (8).
- One sub-module, `frame_gap_timer`, with ports `clk`, `rst_n`, `ena`, `start`, `kick`, `oTimeout`. It is parameterised by TIMEOUT.

## Test plan
- **Key frame**: header A1, payload AC, checksum 0D → `oKey` = 8'hAC, one `oKey_valid` pulse, no error.
- **Message frame**: header A2, payload 64'h0123456789ABCDEF, checksum A2 → `oMessage` updated, `oMsg_valid` pulse, `oKey` unchanged.
- **Bad checksum**: key frame A1, AC, 0C → `oFrame_err` pulse, `oErr_count` = 1, `oKey` unchanged.
- **Bad header**: header 0xB1 (bad sync), then header A0 (reserved opcode) → two error pulses, count = 2, FSM in IDLE after each header byte.
- **Gap timeout**: with TIMEOUT = 4, stop after 20 message bits → error pulse exactly 4 cycles after the last bit; a following valid key frame commits normally.
- **Async reset**: assert `rst_n` low mid-payload → outputs 0 and state IDLE immediately, with no pulses. Also check back-to-back CLEAR frames (A3, A3): both outputs zeroed and both valids pulse on consecutive commits.
